// File: rtl/br_credit_receiver_fifo_flops.sv
// Credit receiver with a flop-based FIFO.
// Terminates a credit/valid link and buffers the accepted beats. Each beat that
// leaves through the ready/valid pop side earns back one credit for the sender.
module br_credit_receiver_fifo_flops #(
  parameter int unsigned Width               = 1,
  parameter int unsigned Depth               = 2,
  parameter int unsigned PushCreditMaxChange = 1,
  parameter bit          RegisterPushOutputs = 1'b0,
  localparam int unsigned CounterWidth       = $clog2(Depth + 1),
  localparam int unsigned PushCreditWidth    = $clog2(PushCreditMaxChange + 1),
  localparam int unsigned CountWidth         = $clog2(Depth + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_sender_in_reset,
  output logic                       push_receiver_in_reset,
  input  logic                       push_credit_stall,
  output logic [PushCreditWidth-1:0] push_credit,
  input  logic                       push_valid,
  input  logic [Width-1:0]           push_data,
  input  logic [CounterWidth-1:0]    credit_initial_push,
  input  logic [CounterWidth-1:0]    credit_withhold_push,
  output logic [CounterWidth-1:0]    credit_count_push,
  output logic [CounterWidth-1:0]    credit_available_push,
  input  logic                       pop_ready,
  output logic                       pop_valid,
  output logic [Width-1:0]           pop_data,
  output logic [CountWidth-1:0]      items,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned SumWidth = CounterWidth + 1;

  // Advance a pointer, wrapping at Depth so non-power-of-2 depths work.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  logic                    in_reset_q;
  logic [CounterWidth-1:0] count_q, count_d;
  logic [CounterWidth-1:0] avail;
  logic [CounterWidth-1:0] max_change;
  logic [CounterWidth-1:0] credit_comb;
  logic [SumWidth-1:0]     count_sum;
  logic                    credit_block;

  logic [Width-1:0]        mem [Depth];
  logic [PtrWidth-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0]   items_q, items_d;
  logic                    push_req, push_en, pop_beat;

  // FIFO status and handshake decode.
  always_comb begin
    pop_valid = (items_q != '0);
    pop_beat  = pop_valid & pop_ready;
    full      = (items_q == CountWidth'(Depth));
    empty     = (items_q == '0);
    // Beats arriving while the sender is in reset are not real traffic.
    push_req  = push_valid & ~push_sender_in_reset;
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    push_en   = push_req & (~full | pop_beat);
    items_d   = items_q;
    unique case ({push_en, pop_beat})
      2'b10:   items_d = items_q + 1'b1;
      2'b01:   items_d = items_q - 1'b1;
      default: items_d = items_q;
    endcase
  end

  // Credit availability, release and counter next state.
  always_comb begin
    avail        = (count_q > credit_withhold_push) ? count_q - credit_withhold_push : '0;
    max_change   = CounterWidth'(PushCreditMaxChange);
    // No credits leave while either side of the link is in reset or stalled.
    credit_block = ~rst_n | in_reset_q | push_sender_in_reset | push_credit_stall;
    credit_comb  = '0;
    if (!credit_block) begin
      credit_comb = (avail < max_change) ? avail : max_change;
    end
    // A pop and a release in the same cycle are netted in one update.
    count_sum = {1'b0, count_q} + SumWidth'(pop_beat) - {1'b0, credit_comb};
    count_d   = count_sum[CounterWidth-1:0];
  end

  // Credit counter and in-reset flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_reset_q <= 1'b1;
      count_q    <= credit_initial_push;
    end else begin
      in_reset_q <= 1'b0;
      count_q    <= count_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      items_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_beat) rd_ptr_q <= ptr_inc(rd_ptr_q);
      items_q <= items_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= push_data;
  end

  // Protocol checks: credit bookkeeping never exceeds Depth, sender never overruns.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count_sum <= SumWidth'(Depth))
        else $error("credit counter exceeds Depth");
      assert (!(push_req && full && !pop_beat))
        else $error("push while full without pop");
    end
  end

  assign pop_data              = mem[rd_ptr_q];
  assign items                 = items_q;
  assign credit_count_push     = count_q;
  assign credit_available_push = avail;

  if (RegisterPushOutputs) begin : g_reg_out
    logic [PushCreditWidth-1:0] push_credit_q;
    logic                       in_reset_out_q;

    // Extra stage on the credit return path; the counter still uses the comb value.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        push_credit_q  <= '0;
        in_reset_out_q <= 1'b1;
      end else begin
        push_credit_q  <= PushCreditWidth'(credit_comb);
        in_reset_out_q <= in_reset_q;
      end
    end

    assign push_credit            = push_credit_q;
    assign push_receiver_in_reset = in_reset_out_q;
  end else begin : g_comb_out
    assign push_credit            = PushCreditWidth'(credit_comb);
    assign push_receiver_in_reset = in_reset_q;
  end

endmodule
